// File: rtl/arf132b256e1r1w0cbbehcaa4acw_cg_pkg.sv
// Shared definitions for the banked register-file clock-gate controller:
// per-bank state encoding, default parameters and the bank-select decode.
package arf132b256e1r1w0cbbehcaa4acw_cg_pkg;

  typedef logic [1:0] cg_state_t;

  localparam cg_state_t ST_OFF  = 2'b00;
  localparam cg_state_t ST_WAKE = 2'b01;
  localparam cg_state_t ST_ON   = 2'b10;

  localparam int DEF_NUM_BANKS   = 4;
  localparam int DEF_WAKE_LAT    = 2;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_CNT_W       = 8;

  // True when a valid request addresses bank idx; indices at or beyond
  // num_banks never select anything.
  function automatic logic bank_match(input logic        valid,
                                      input int unsigned bank,
                                      input int unsigned idx,
                                      input int unsigned num_banks);
    return valid && (bank == idx) && (idx < num_banks);
  endfunction

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_bank_cg_fsm.sv
// One bank's gating FSM with its shared wake/idle counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   OFF     | bank clock gated, waiting for a request
//   WAKE    | clock running, settling for WAKE_LAT cycles, no accesses
//   ON      | accesses accepted; re-gates after IDLE_CYCLES idle cycles
module arf132b256e1r1w0cbbehcaa4acw_bank_cg_fsm
  import arf132b256e1r1w0cbbehcaa4acw_cg_pkg::*;
#(
  parameter int WAKE_LAT    = DEF_WAKE_LAT,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       cg_dis,
  output logic [1:0] state,
  output logic       clk_en
);

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAT - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // State and counter update; cg_dis pins the bank ON with a cleared counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else if (cg_dis) begin
      state <= ST_ON;
      cnt   <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          cnt <= '0;
          if (hit) state <= ST_WAKE;
        end
        ST_WAKE: begin
          if (cnt == WAKE_LAST) begin
            state <= ST_ON;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ON: begin
          // A hit on the last idle cycle wins over re-gating.
          if (hit) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            state <= ST_OFF;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Clock runs in WAKE too, so the bank is settled before its first access.
  assign clk_en = (state != ST_OFF) || cg_dis;

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_clk_and.sv
// Latch-based clock gate: the enable is captured while clk is low so the
// gated clock can only change on the rising edge of clk, never glitch.
module arf132b256e1r1w0cbbehcaa4acw_clk_and (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Transparent while clk is low, holds through the high phase.
  always_latch begin
    if (!clk) en_lat = en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl.sv
// Per-bank clock-gate controller for the banked 1R1W register file.
// Each bank has its own FSM and gate cell; port ready is decoded from
// registered bank state only.
module arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl
  import arf132b256e1r1w0cbbehcaa4acw_cg_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int WAKE_LAT    = DEF_WAKE_LAT,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [BANK_W-1:0]    wr_bank,
  output logic                 wr_ready,
  input  logic                 rd_valid,
  input  logic [BANK_W-1:0]    rd_bank,
  output logic                 rd_ready,
  input  logic                 cg_dis,
  input  logic                 fscan_clkungate,
  output logic [NUM_BANKS-1:0] bank_clk_en,
  output logic [NUM_BANKS-1:0] bank_clk,
  output logic [NUM_BANKS-1:0] bank_on
);

  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_chk_banks
    $error("NUM_BANKS must be in 1..16");
  end
  if (WAKE_LAT < 1) begin : g_chk_wake
    $error("WAKE_LAT must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : g_chk_idle
    $error("IDLE_CYCLES must be >= 1");
  end
  if (CNT_W < $clog2(IDLE_CYCLES + 1) || CNT_W < $clog2(WAKE_LAT + 1)) begin : g_chk_cnt
    $error("CNT_W too narrow for IDLE_CYCLES/WAKE_LAT");
  end

  logic [NUM_BANKS-1:0] hit;
  logic [NUM_BANKS-1:0] wr_sel;
  logic [NUM_BANKS-1:0] rd_sel;
  logic [NUM_BANKS-1:0] fsm_en;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0] st;

    // Bank select decode; a hit needs valid, a select is used for ready.
    assign wr_sel[b] = bank_match(1'b1, 32'(wr_bank), b, NUM_BANKS);
    assign rd_sel[b] = bank_match(1'b1, 32'(rd_bank), b, NUM_BANKS);
    assign hit[b]    = (wr_valid && wr_sel[b]) || (rd_valid && rd_sel[b]);

    arf132b256e1r1w0cbbehcaa4acw_bank_cg_fsm #(
      .WAKE_LAT    (WAKE_LAT),
      .IDLE_CYCLES (IDLE_CYCLES),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .hit    (hit[b]),
      .cg_dis (cg_dis),
      .state  (st),
      .clk_en (fsm_en[b])
    );

    assign bank_on[b]     = (st == ST_ON);
    assign bank_clk_en[b] = fsm_en[b] || fscan_clkungate;

    arf132b256e1r1w0cbbehcaa4acw_clk_and u_cg (
      .clk  (clk),
      .en   (bank_clk_en[b]),
      .gclk (bank_clk[b])
    );
  end

  // Out-of-range bank indices select nothing, so their ready stays low.
  assign wr_ready = |(wr_sel & bank_on);
  assign rd_ready = |(rd_sel & bank_on);

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl.sv
// Directed bench for the bank clock-gate controller. A 4-bank instance
// covers the main behaviour; a 3-bank instance sharing the same inputs
// covers the out-of-range bank index.
module tb_arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [1:0] wr_bank;
  logic       rd_valid;
  logic [1:0] rd_bank;
  logic       cg_dis;
  logic       fscan_clkungate;

  logic       wr_ready, rd_ready;
  logic [3:0] bank_clk_en, bank_clk, bank_on;

  logic       wr_ready3, rd_ready3;
  logic [2:0] bank_clk_en3, bank_clk3, bank_on3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_bank         (wr_bank),
    .wr_ready        (wr_ready),
    .rd_valid        (rd_valid),
    .rd_bank         (rd_bank),
    .rd_ready        (rd_ready),
    .cg_dis          (cg_dis),
    .fscan_clkungate (fscan_clkungate),
    .bank_clk_en     (bank_clk_en),
    .bank_clk        (bank_clk),
    .bank_on         (bank_on)
  );

  arf132b256e1r1w0cbbehcaa4acw_bank_cg_ctrl #(.NUM_BANKS(3)) u_dut3 (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_bank         (wr_bank),
    .wr_ready        (wr_ready3),
    .rd_valid        (rd_valid),
    .rd_bank         (rd_bank),
    .rd_ready        (rd_ready3),
    .cg_dis          (cg_dis),
    .fscan_clkungate (fscan_clkungate),
    .bank_clk_en     (bank_clk_en3),
    .bank_clk        (bank_clk3),
    .bank_on         (bank_on3)
  );

  // Advance one cycle; sampling point is 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    wr_valid = 1'b0; wr_bank = 2'd0;
    rd_valid = 1'b0; rd_bank = 2'd0;
    cg_dis = 1'b0; fscan_clkungate = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    wr_valid = 1'b1; wr_bank = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bank_clk_en, bank_on, wr_ready, rd_ready} !== 10'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d en=%b on=%b wr_rdy=%b rd_rdy=%b required all 0",
                 i, bank_clk_en, bank_on, wr_ready, rd_ready);
      end
    end
    checks++;
    if (bank_clk !== 4'b0000) begin
      errors++;
      $display("FAIL reset_bank_clk got %b required 0000", bank_clk);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bank_clk_en !== 4'b0001 || bank_on !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_wake en=%b on=%b required en=0001 on=0000", bank_clk_en, bank_on);
    end
    clear_inputs();
  endtask

  task automatic test_cold_wake();
    apply_reset();
    rd_valid = 1'b1; rd_bank = 2'd2;
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if (bank_clk_en !== 4'b0100 || rd_ready !== 1'b0 || bank_on !== 4'b0000) begin
        errors++;
        $display("FAIL cold_wake_c%0d en=%b rd_rdy=%b on=%b required en=0100 rd_rdy=0 on=0000",
                 c, bank_clk_en, rd_ready, bank_on);
      end
    end
    step();
    checks++;
    if (rd_ready !== 1'b1 || bank_on !== 4'b0100) begin
      errors++;
      $display("FAIL cold_wake_c3 rd_rdy=%b on=%b required rd_rdy=1 on=0100", rd_ready, bank_on);
    end
    clear_inputs();
  endtask

  // Wake bank 1 through the write port; one transfer happens on the ON cycle.
  task automatic wake_bank1();
    apply_reset();
    wr_valid = 1'b1; wr_bank = 2'd1;
    step(); step(); step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_setup_ready got %b required 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_idle_regate();
    wake_bank1();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bank_clk_en[1] !== 1'b1 || bank_on[1] !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold_%0d en1=%b on1=%b required 1 1", i, bank_clk_en[1], bank_on[1]);
      end
      step();
    end
    checks++;
    if (bank_clk_en[1] !== 1'b0 || bank_on[1] !== 1'b0) begin
      errors++;
      $display("FAIL idle_regate en1=%b on1=%b required 0 0", bank_clk_en[1], bank_on[1]);
    end

    // Hit on the 8th idle cycle keeps the bank ON and restarts the window.
    wake_bank1();
    for (int i = 1; i <= 7; i++) step();
    wr_valid = 1'b1; wr_bank = 2'd1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_last_hit_ready got %b required 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (bank_on[1] !== 1'b1) begin
      errors++;
      $display("FAIL idle_last_hit_on got %b required 1", bank_on[1]);
    end
    for (int i = 1; i <= 7; i++) step();
    checks++;
    if (bank_on[1] !== 1'b1) begin
      errors++;
      $display("FAIL idle_restart_hold got %b required 1", bank_on[1]);
    end
    step();
    checks++;
    if (bank_on[1] !== 1'b0 || bank_clk_en[1] !== 1'b0) begin
      errors++;
      $display("FAIL idle_restart_off on1=%b en1=%b required 0 0", bank_on[1], bank_clk_en[1]);
    end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    apply_reset();
    wr_valid = 1'b1; wr_bank = 2'd0;
    step(); step(); step();
    rd_valid = 1'b1; rd_bank = 2'd3;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL conc_start wr_rdy=%b rd_rdy=%b required 1 0", wr_ready, rd_ready);
    end
    step();
    step();
    checks++;
    if (rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL conc_wait wr_rdy=%b rd_rdy=%b required 1 0", wr_ready, rd_ready);
    end
    step();
    checks++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b1 || bank_on !== 4'b1001) begin
      errors++;
      $display("FAIL conc_rd_ready wr_rdy=%b rd_rdy=%b on=%b required 1 1 1001",
               wr_ready, rd_ready, bank_on);
    end
    rd_bank = 2'd0;
    #1;
    checks++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL conc_same_bank wr_rdy=%b rd_rdy=%b required 1 1", wr_ready, rd_ready);
    end
    clear_inputs();
  endtask

  task automatic test_overrides();
    apply_reset();
    cg_dis = 1'b1;
    #1;
    checks++;
    if (bank_clk_en !== 4'b1111 || bank_on !== 4'b0000) begin
      errors++;
      $display("FAIL cgdis_comb en=%b on=%b required 1111 0000", bank_clk_en, bank_on);
    end
    step();
    checks++;
    if (bank_on !== 4'b1111) begin
      errors++;
      $display("FAIL cgdis_on got %b required 1111", bank_on);
    end
    cg_dis = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    checks++;
    if (bank_on !== 4'b1111 || bank_clk_en !== 4'b1111) begin
      errors++;
      $display("FAIL cgdis_release_hold on=%b en=%b required 1111 1111", bank_on, bank_clk_en);
    end
    step();
    checks++;
    if (bank_on !== 4'b0000 || bank_clk_en !== 4'b0000) begin
      errors++;
      $display("FAIL cgdis_release_off on=%b en=%b required 0000 0000", bank_on, bank_clk_en);
    end
    fscan_clkungate = 1'b1;
    #1;
    checks++;
    if (bank_clk_en !== 4'b1111 || bank_on !== 4'b0000) begin
      errors++;
      $display("FAIL scan_comb en=%b on=%b required 1111 0000", bank_clk_en, bank_on);
    end
    step(); step();
    checks++;
    if (bank_on !== 4'b0000 || bank_clk !== 4'b1111) begin
      errors++;
      $display("FAIL scan_fsm on=%b gclk=%b required 0000 1111", bank_on, bank_clk);
    end
    fscan_clkungate = 1'b0;
    step(); step();
    checks++;
    if (bank_clk_en !== 4'b0000 || bank_clk !== 4'b0000) begin
      errors++;
      $display("FAIL scan_release en=%b gclk=%b required 0000 0000", bank_clk_en, bank_clk);
    end
    clear_inputs();
  endtask

  task automatic test_midwake_range();
    apply_reset();
    wr_valid = 1'b1; wr_bank = 2'd1;
    step();
    checks++;
    if (bank_clk_en3 !== 3'b010 || bank_on3 !== 3'b000) begin
      errors++;
      $display("FAIL midwake_enter en=%b on=%b required 010 000", bank_clk_en3, bank_on3);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bank_clk_en3 !== 3'b000 || bank_on3 !== 3'b000 || wr_ready3 !== 1'b0) begin
      errors++;
      $display("FAIL midwake_reset en=%b on=%b wr_rdy=%b required 000 000 0",
               bank_clk_en3, bank_on3, wr_ready3);
    end
    rst = 1'b0;
    wr_valid = 1'b1; wr_bank = 2'd3;
    rd_valid = 1'b1; rd_bank = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bank_clk_en3 !== 3'b000 || wr_ready3 !== 1'b0 || rd_ready3 !== 1'b0) begin
        errors++;
        $display("FAIL range_bank3_%0d en=%b wr_rdy=%b rd_rdy=%b required 000 0 0",
                 i, bank_clk_en3, wr_ready3, rd_ready3);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_cold_wake();
    test_idle_regate();
    test_concurrent();
    test_overrides();
    test_midwake_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
